// File: rtl/conv_pkg.sv
// Shared definitions for the subframe window sequencing blocks.
package conv_pkg;

  // Controller states for one padded frame
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    RESYNC,
    DONE
  } state_t;

  localparam int NB_PIXEL     = 8;
  localparam int PIX_PER_WORD = 4;

  // Number of vertical strips a padded image is split into
  function automatic int strip_count(input int width, input int pix_per_word);
    return width / pix_per_word;
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Row/strip position of the next accepted word; rows wrap into the next strip.
module frame_pos_counter #(
  parameter int IMAGE_HEIGHT = 200,
  parameter int NUM_STRIPS   = 50,
  parameter int NB_ROW       = $clog2(IMAGE_HEIGHT),
  parameter int NB_STRIP     = $clog2(NUM_STRIPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  output logic [NB_ROW-1:0]   row,
  output logic [NB_STRIP-1:0] strip,
  output logic                last_word
);

  localparam logic [NB_ROW-1:0]   ROW_LAST   = NB_ROW'(IMAGE_HEIGHT - 1);
  localparam logic [NB_STRIP-1:0] STRIP_LAST = NB_STRIP'(NUM_STRIPS - 1);

  assign last_word = (row == ROW_LAST) && (strip == STRIP_LAST);

  // Step down the strip one row per word, then move one strip to the right
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row   <= '0;
      strip <= '0;
    end else if (clear) begin
      row   <= '0;
      strip <= '0;
    end else if (advance) begin
      if (row == ROW_LAST) begin
        row   <= '0;
        strip <= (strip == STRIP_LAST) ? '0 : strip + NB_STRIP'(1);
      end else begin
        row <= row + NB_ROW'(1);
      end
    end
  end

endmodule

// File: rtl/subframe_ctrl.sv
// Sequences the subframe window generator over one padded frame of pixel words.
module subframe_ctrl #(
  parameter int IMAGE_HEIGHT = 200,
  parameter int IMAGE_WIDTH  = 200,
  parameter int PIX_PER_WORD = conv_pkg::PIX_PER_WORD,
  parameter int NB_DATA      = 32,
  parameter int NB_ROW       = $clog2(IMAGE_HEIGHT),
  parameter int NB_STRIP     = $clog2(IMAGE_WIDTH / PIX_PER_WORD)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_DATA-1:0]  i_s_tdata,
  input  logic                i_s_tvalid,
  input  logic                i_s_tlast,
  output logic                o_s_tready,
  output logic [NB_DATA-1:0]  o_sf_data,
  output logic                o_sf_valid,
  output logic                o_sf_clear,
  output logic                o_conv_valid,
  input  logic                i_conv_ready,
  output logic [NB_ROW-1:0]   o_row,
  output logic [NB_STRIP-1:0] o_strip,
  output logic                o_frame_done,
  output logic                o_err_tlast
);

  import conv_pkg::state_t;
  import conv_pkg::IDLE;
  import conv_pkg::CLEAR;
  import conv_pkg::RUN;
  import conv_pkg::RESYNC;
  import conv_pkg::DONE;

  localparam int NUM_STRIPS = conv_pkg::strip_count(IMAGE_WIDTH, PIX_PER_WORD);

  state_t              state;
  state_t              next_state;
  logic                acc;
  logic                qual;
  logic                err_set;
  logic [NB_ROW-1:0]   cur_row;
  logic [NB_STRIP-1:0] cur_strip;
  logic                last_word;

  assign o_sf_data  = i_s_tdata;
  assign acc        = i_s_tvalid & o_s_tready;
  assign o_sf_valid = (state == RUN) & acc;
  assign qual       = o_sf_valid & (cur_row >= NB_ROW'(2));

  frame_pos_counter #(
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .NUM_STRIPS   (NUM_STRIPS),
    .NB_ROW       (NB_ROW),
    .NB_STRIP     (NB_STRIP)
  ) u_pos (
    .clk       (i_clk),
    .rst       (i_reset),
    .clear     (o_sf_clear),
    .advance   (o_sf_valid),
    .row       (cur_row),
    .strip     (cur_strip),
    .last_word (last_word)
  );

  // Stream ready: stall only while an unconsumed window is pending; RESYNC drains freely
  always_comb begin
    o_s_tready = 1'b0;
    case (state)
      RUN:     o_s_tready = ~o_conv_valid | i_conv_ready;
      RESYNC:  o_s_tready = 1'b1;
      default: o_s_tready = 1'b0;
    endcase
  end

  // Next state, generator clear, framing-error detection and completion pulse
  always_comb begin
    next_state   = state;
    o_sf_clear   = 1'b0;
    o_frame_done = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) next_state = CLEAR;
      end
      CLEAR: begin
        o_sf_clear = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        if (acc) begin
          if (last_word) begin
            if (i_s_tlast) begin
              next_state = DONE;
            end else begin
              err_set    = 1'b1;
              next_state = RESYNC;
            end
          end else if (i_s_tlast) begin
            err_set    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      RESYNC: begin
        if (acc && i_s_tlast) next_state = IDLE;
      end
      DONE: begin
        if (!o_conv_valid) begin
          o_frame_done = 1'b1;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Sticky framing error, wiped when a new frame is armed
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)               o_err_tlast <= 1'b0;
    else if (state == CLEAR)   o_err_tlast <= 1'b0;
    else if (err_set)          o_err_tlast <= 1'b1;
  end

  // Window valid and its position; a new qualifying beat wins over consumption
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_conv_valid <= 1'b0;
      o_row        <= '0;
      o_strip      <= '0;
    end else if (qual) begin
      o_conv_valid <= 1'b1;
      o_row        <= cur_row;
      o_strip      <= cur_strip;
    end else if (i_conv_ready) begin
      o_conv_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_subframe_ctrl.sv
// Self-checking bench for subframe_ctrl on a 5-row, 8-pixel-wide padded image.
module tb_subframe_ctrl;

  localparam int H           = 5;
  localparam int W           = 8;
  localparam int PPW         = 4;
  localparam int NBD         = 32;
  localparam int NBR         = $clog2(H);
  localparam int NBS         = $clog2(W / PPW);
  localparam int STRIPS      = W / PPW;
  localparam int FRAME_WORDS = H * STRIPS;

  logic           i_clk        = 1'b0;
  logic           i_reset      = 1'b1;
  logic           i_enable     = 1'b0;
  logic [NBD-1:0] i_s_tdata    = '0;
  logic           i_s_tvalid   = 1'b0;
  logic           i_s_tlast    = 1'b0;
  logic           i_conv_ready = 1'b1;
  logic           o_s_tready;
  logic [NBD-1:0] o_sf_data;
  logic           o_sf_valid;
  logic           o_sf_clear;
  logic           o_conv_valid;
  logic [NBR-1:0] o_row;
  logic [NBS-1:0] o_strip;
  logic           o_frame_done;
  logic           o_err_tlast;

  subframe_ctrl #(
    .IMAGE_HEIGHT (H),
    .IMAGE_WIDTH  (W),
    .PIX_PER_WORD (PPW),
    .NB_DATA      (NBD)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_s_tdata    (i_s_tdata),
    .i_s_tvalid   (i_s_tvalid),
    .i_s_tlast    (i_s_tlast),
    .o_s_tready   (o_s_tready),
    .o_sf_data    (o_sf_data),
    .o_sf_valid   (o_sf_valid),
    .o_sf_clear   (o_sf_clear),
    .o_conv_valid (o_conv_valid),
    .i_conv_ready (i_conv_ready),
    .o_row        (o_row),
    .o_strip      (o_strip),
    .o_frame_done (o_frame_done),
    .o_err_tlast  (o_err_tlast)
  );

  initial forever #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Observations, written only by the monitor
  int             obs_win[$];
  logic [NBD-1:0] obs_data[$];
  int             done_cnt   = 0;
  int             clear_cnt  = 0;
  int             clear_mark = 0;

  // Expectations, written only by the main flow
  int             exp_win[$];
  logic [NBD-1:0] sent_data[$];
  int             win_base, data_base, done_base, clear_base;
  bit             rand_ready = 1'b0;

  typedef struct {
    string name;
    int    n_words;
    int    gap_mode;
    bit    bp;
    int    exp_sfv;
    bit    exp_err;
    int    exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor sampling on the falling edge, away from the active edge
  initial forever begin
    @(negedge i_clk);
    if (o_sf_clear) begin
      clear_cnt++;
      clear_mark = obs_data.size();
    end
    if (o_sf_valid) begin
      checkOutput("sf_valid_handshake", {62'd0, i_s_tvalid, o_s_tready}, 64'd3);
      checkOutput("sf_data_passthru", o_sf_data, i_s_tdata);
      obs_data.push_back(o_sf_data);
    end
    if (o_conv_valid && i_conv_ready) obs_win.push_back(int'(o_row) * 16 + int'(o_strip));
    if (o_conv_valid && !i_conv_ready && !o_err_tlast) checkOutput("stall_tready", o_s_tready, 0);
    if (o_frame_done) done_cnt++;
  end

  // Random consumer readiness, driven later in the cycle than the main flow
  initial forever begin
    @(posedge i_clk);
    #2;
    if (rand_ready) i_conv_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Reference: position k of the frame is row k%H of strip k/H; windows come from rows >= 2
  task automatic model_frame(input int n, output int sfv, output bit err, output int done);
    int row;
    int strip;
    bit last;
    exp_win.delete();
    sfv  = 0;
    err  = 1'b0;
    done = 0;
    for (int k = 0; k < n; k++) begin
      last = (k == n - 1);
      if (k >= FRAME_WORDS) continue;
      row   = k % H;
      strip = k / H;
      sfv++;
      if (row >= 2) exp_win.push_back(row * 16 + strip);
      if (k == FRAME_WORDS - 1) begin
        if (last) done = 1;
        else      err  = 1'b1;
      end else if (last) begin
        err = 1'b1;
        break;
      end
    end
  endtask

  task automatic snapshot();
    win_base   = obs_win.size();
    data_base  = obs_data.size();
    done_base  = done_cnt;
    clear_base = clear_cnt;
    sent_data.delete();
  endtask

  task automatic send_word(input logic [NBD-1:0] d, input bit last, input int gaps);
    bit got;
    repeat (gaps) begin
      i_s_tvalid = 1'b0;
      i_s_tdata  = $urandom;
      @(posedge i_clk);
      #1;
    end
    i_s_tvalid = 1'b1;
    i_s_tdata  = d;
    i_s_tlast  = last;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge i_clk);
      got = o_s_tready;
      @(posedge i_clk);
      #1;
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    i_s_tvalid = 1'b0;
    i_s_tlast  = 1'b0;
  endtask

  task automatic applyStimulus(input int n_words, input int gap_mode);
    logic [NBD-1:0] d;
    int gaps;
    @(posedge i_clk);
    #1 i_enable = 1'b1;
    @(posedge i_clk);
    #1 i_enable = 1'b0;
    for (int k = 0; k < n_words; k++) begin
      d = $urandom;
      sent_data.push_back(d);
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
      send_word(d, k == n_words - 1, gaps);
    end
  endtask

  task automatic drain();
    rand_ready   = 1'b0;
    i_conv_ready = 1'b1;
    repeat (8) @(posedge i_clk);
    #1;
  endtask

  task automatic compare_frame(input string tag, input int exp_sfv, input bit exp_err, input int exp_done);
    int nw;
    int nd;
    nw = obs_win.size() - win_base;
    nd = obs_data.size() - data_base;
    checkOutput({tag, " windows"}, nw, exp_win.size());
    for (int i = 0; i < nw && i < exp_win.size(); i++)
      checkOutput({tag, " win_pos"}, obs_win[win_base + i], exp_win[i]);
    checkOutput({tag, " sf_valid_beats"}, nd, exp_sfv);
    for (int i = 0; i < nd && i < exp_sfv; i++)
      checkOutput({tag, " sf_data"}, obs_data[data_base + i], sent_data[i]);
    checkOutput({tag, " frame_done"}, done_cnt - done_base, exp_done);
    checkOutput({tag, " clear_pulses"}, clear_cnt - clear_base, 1);
    checkOutput({tag, " clear_first"}, clear_mark, data_base);
    checkOutput({tag, " err_tlast"}, o_err_tlast, exp_err);
    checkOutput({tag, " idle_tready"}, o_s_tready, 0);
    checkOutput({tag, " conv_valid_idle"}, o_conv_valid, 0);
  endtask

  initial begin
    int sfv;
    bit err;
    int done;
    int n;

    vecs[0] = '{"nominal",       10, 0, 1'b0, 10, 1'b0, 1};
    vecs[1] = '{"backpressure",  10, 0, 1'b1, 10, 1'b0, 1};
    vecs[2] = '{"early_tlast",    7, 0, 1'b0,  7, 1'b1, 0};
    vecs[3] = '{"after_error",   10, 0, 1'b0, 10, 1'b0, 1};
    vecs[4] = '{"missing_tlast", 13, 0, 1'b0, 10, 1'b1, 0};
    vecs[5] = '{"gapped",        10, 1, 1'b0, 10, 1'b0, 1};

    // Outputs while reset is held
    #3;
    checkOutput("rst tready",     o_s_tready,   0);
    checkOutput("rst sf_valid",   o_sf_valid,   0);
    checkOutput("rst sf_clear",   o_sf_clear,   0);
    checkOutput("rst conv_valid", o_conv_valid, 0);
    checkOutput("rst row",        o_row,        0);
    checkOutput("rst strip",      o_strip,      0);
    checkOutput("rst frame_done", o_frame_done, 0);
    checkOutput("rst err_tlast",  o_err_tlast,  0);
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    foreach (vecs[v]) begin
      snapshot();
      model_frame(vecs[v].n_words, sfv, err, done);
      if (vecs[v].bp) begin
        i_conv_ready = 1'b0;
        fork
          applyStimulus(vecs[v].n_words, vecs[v].gap_mode);
          begin
            int c;
            c = 0;
            @(negedge i_clk);
            while (!o_conv_valid && c < 300) begin
              @(negedge i_clk);
              c++;
            end
            checkOutput("bp first_window_seen", o_conv_valid, 1);
            for (int i = 0; i < 4; i++) begin
              checkOutput("bp tready",     o_s_tready,   0);
              checkOutput("bp sf_valid",   o_sf_valid,   0);
              checkOutput("bp row_held",   o_row,        2);
              checkOutput("bp conv_valid", o_conv_valid, 1);
              if (i < 3) @(negedge i_clk);
            end
            @(posedge i_clk);
            #1 i_conv_ready = 1'b1;
          end
        join
      end else begin
        applyStimulus(vecs[v].n_words, vecs[v].gap_mode);
      end
      drain();
      compare_frame(vecs[v].name, vecs[v].exp_sfv, vecs[v].exp_err, vecs[v].exp_done);
    end

    // Asynchronous reset in the middle of a frame
    snapshot();
    @(posedge i_clk);
    #1 i_enable = 1'b1;
    @(posedge i_clk);
    #1 i_enable = 1'b0;
    for (int k = 0; k < 4; k++) send_word($urandom, 1'b0, 0);
    checkOutput("midrst pre conv_valid", o_conv_valid, 1);
    checkOutput("midrst pre row",        o_row,        3);
    i_s_tvalid = 1'b1;
    #2 i_reset = 1'b1;
    #1;
    checkOutput("midrst tready",     o_s_tready,   0);
    checkOutput("midrst sf_valid",   o_sf_valid,   0);
    checkOutput("midrst sf_clear",   o_sf_clear,   0);
    checkOutput("midrst conv_valid", o_conv_valid, 0);
    checkOutput("midrst row",        o_row,        0);
    checkOutput("midrst strip",      o_strip,      0);
    checkOutput("midrst frame_done", o_frame_done, 0);
    checkOutput("midrst err_tlast",  o_err_tlast,  0);
    i_s_tvalid = 1'b0;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    snapshot();
    model_frame(FRAME_WORDS, sfv, err, done);
    applyStimulus(FRAME_WORDS, 0);
    drain();
    compare_frame("after_reset", sfv, err, done);

    // Randomized frames: random gaps, random consumer readiness, random framing
    for (int f = 0; f < 20; f++) begin
      case ($urandom_range(0, 3))
        0, 1:    n = FRAME_WORDS;
        2:       n = $urandom_range(1, FRAME_WORDS - 1);
        default: n = $urandom_range(FRAME_WORDS + 1, FRAME_WORDS + 4);
      endcase
      snapshot();
      model_frame(n, sfv, err, done);
      rand_ready = 1'b1;
      applyStimulus(n, 2);
      drain();
      compare_frame($sformatf("random%0d_n%0d", f, n), sfv, err, done);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
